// File: rtl/ecc_banked_mem.sv
// Dual-port banked word memory with per-bank arbitration and pipelined reads.
// Optional SECDED storage when ECC_BANKED_MEM_ECC_EN is defined.
module ecc_banked_mem #(
  parameter int WIDTH        = 8,
  parameter int ADDR_WIDTH   = 5,
  parameter int NUM_BANK     = 4,
  parameter int READ_LATENCY = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_a,
  input  logic                  i_we_a,
  input  logic [ADDR_WIDTH-1:0] i_addr_a,
  input  logic [WIDTH-1:0]      i_din_a,
  input  logic [1:0]            i_inj_a,
  output logic                  o_ready_a,
  output logic                  o_rvalid_a,
  output logic [WIDTH-1:0]      o_dout_a,
  output logic                  o_sbe_a,
  output logic                  o_dbe_a,
  input  logic                  i_req_b,
  input  logic                  i_we_b,
  input  logic [ADDR_WIDTH-1:0] i_addr_b,
  input  logic [WIDTH-1:0]      i_din_b,
  input  logic [1:0]            i_inj_b,
  output logic                  o_ready_b,
  output logic                  o_rvalid_b,
  output logic [WIDTH-1:0]      o_dout_b,
  output logic                  o_sbe_b,
  output logic                  o_dbe_b
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] BMASK = ADDR_WIDTH'(NUM_BANK-1);

`ifdef ECC_BANKED_MEM_ECC_EN
  function automatic int calc_p(input int w);
    int r;
    r = 1;
    for (int p = 7; p >= 1; p--)
      if ((1 << p) >= w + p + 1) r = p;
    return r;
  endfunction

  localparam int P  = calc_p(WIDTH);
  localparam int N  = WIDTH + P;
  localparam int CW = N + 1;

  // Bit 0 is overall parity; bits 1..N use classic Hamming positions.
  function automatic logic [CW-1:0] enc(input logic [WIDTH-1:0] d);
    logic [CW-1:0] c;
    int j;
    int s;
    c = '0;
    j = 0;
    s = 0;
    for (int pos = 1; pos <= N; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos] = d[j];
        if (d[j]) s = s ^ pos;
        j++;
      end
    end
    for (int i = 0; i < P; i++) c[1 << i] = s[i];
    c[0] = ^c[N:1];
    return c;
  endfunction

  function automatic logic [WIDTH+1:0] dec(input logic [CW-1:0] c);
    logic [CW-1:0]    f;
    logic [WIDTH-1:0] d;
    logic             sbe;
    logic             dbe;
    int               s;
    int               j;
    s = 0;
    for (int pos = 1; pos <= N; pos++)
      if (c[pos]) s = s ^ pos;
    f   = c;
    sbe = 1'b0;
    dbe = 1'b0;
    if (^c) begin
      if (s <= N) begin
        f[s] = ~f[s];
        sbe  = 1'b1;
      end else begin
        dbe = 1'b1;
      end
    end else if (s != 0) begin
      dbe = 1'b1;
    end
    d = '0;
    j = 0;
    for (int pos = 1; pos <= N; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[j] = f[pos];
        j++;
      end
    end
    return {dbe, sbe, d};
  endfunction

  function automatic logic [CW-1:0] inj_mask(input logic [1:0] inj);
    logic [CW-1:0] m;
    m = '0;
    unique case (inj)
      2'b01:   m[0]   = 1'b1;
      2'b10:   m[1:0] = 2'b11;
      default: m      = '0;
    endcase
    return m;
  endfunction

  logic [CW-1:0] wcw_a;
  logic [CW-1:0] wcw_b;
  assign wcw_a = enc(i_din_a) ^ inj_mask(i_inj_a);
  assign wcw_b = enc(i_din_b) ^ inj_mask(i_inj_b);
`else
  localparam int CW = WIDTH;

  function automatic logic [WIDTH+1:0] dec(input logic [CW-1:0] c);
    return {2'b00, c};
  endfunction

  logic [CW-1:0] wcw_a;
  logic [CW-1:0] wcw_b;
  logic          unused_inj;
  assign wcw_a      = i_din_a;
  assign wcw_b      = i_din_b;
  assign unused_inj = ^{i_inj_a, i_inj_b};
`endif

  logic conflict;
  logic prio_b;
  logic acc_a;
  logic acc_b;

  assign conflict  = i_req_a & i_req_b
                   & (((i_addr_a ^ i_addr_b) & BMASK) == '0);
  assign o_ready_a = ~(conflict & prio_b);
  assign o_ready_b = ~(conflict & ~prio_b);
  assign acc_a     = i_req_a & o_ready_a;
  assign acc_b     = i_req_b & o_ready_b;

  // The loser of a conflict gets priority next time.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) prio_b <= 1'b0;
    else if (conflict) prio_b <= ~prio_b;
  end

  logic [CW-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (acc_a & i_we_a) mem[i_addr_a] <= wcw_a;
    if (acc_b & i_we_b) mem[i_addr_b] <= wcw_b;
  end

  logic [1:0]            rd_acc;
  logic [ADDR_WIDTH-1:0] raddr [2];
  logic [1:0]            rv;
  logic [1:0]            sb;
  logic [1:0]            db;
  logic [WIDTH-1:0]      rd [2];

  assign rd_acc   = {acc_b & ~i_we_b, acc_a & ~i_we_a};
  assign raddr[0] = i_addr_a;
  assign raddr[1] = i_addr_b;

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic                   v0;
    logic [CW-1:0]          c0;
    logic [WIDTH+1:0]       dq;
    logic [READ_LATENCY:1]  v;
    logic [READ_LATENCY:1]  s;
    logic [READ_LATENCY:1]  e;
    logic [WIDTH-1:0]       d [1:READ_LATENCY];

    assign dq = dec(c0);

    // Raw codeword is captured at accept; decode sits between stage 0 and 1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        v0 <= 1'b0;
        c0 <= '0;
        v  <= '0;
        s  <= '0;
        e  <= '0;
        for (int k = 1; k <= READ_LATENCY; k++) d[k] <= '0;
      end else begin
        v0 <= rd_acc[p];
        if (rd_acc[p]) c0 <= mem[raddr[p]];
        v[1] <= v0;
        s[1] <= v0 & dq[WIDTH];
        e[1] <= v0 & dq[WIDTH+1];
        if (v0) d[1] <= dq[WIDTH-1:0];
        for (int k = 2; k <= READ_LATENCY; k++) begin
          v[k] <= v[k-1];
          s[k] <= v[k-1] & s[k-1];
          e[k] <= v[k-1] & e[k-1];
          if (v[k-1]) d[k] <= d[k-1];
        end
      end
    end

    assign rv[p] = v[READ_LATENCY];
    assign sb[p] = s[READ_LATENCY];
    assign db[p] = e[READ_LATENCY];
    assign rd[p] = d[READ_LATENCY];
  end

  assign o_rvalid_a = rv[0];
  assign o_sbe_a    = sb[0];
  assign o_dbe_a    = db[0];
  assign o_dout_a   = rd[0];
  assign o_rvalid_b = rv[1];
  assign o_sbe_b    = sb[1];
  assign o_dbe_b    = db[1];
  assign o_dout_b   = rd[1];

endmodule

// File: tb/tb_ecc_banked_mem.sv
// Directed plus random checks of ecc_banked_mem against a word-level model.
// Expects SECDED flags only when ECC_BANKED_MEM_ECC_EN is defined.
module tb_ecc_banked_mem;

  localparam int W     = 8;
  localparam int AW    = 5;
  localparam int NB    = 4;
  localparam int L     = 2;
  localparam int DEPTH = 32;
`ifdef ECC_BANKED_MEM_ECC_EN
  localparam bit ECC = 1'b1;
`else
  localparam bit ECC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_a = 0, we_a = 0, req_b = 0, we_b = 0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [W-1:0]  din_a = '0, din_b = '0;
  logic [1:0]    inj_a = '0, inj_b = '0;
  logic          ready_a, rvalid_a, sbe_a, dbe_a;
  logic          ready_b, rvalid_b, sbe_b, dbe_b;
  logic [W-1:0]  dout_a, dout_b;

  ecc_banked_mem #(
    .WIDTH(W), .ADDR_WIDTH(AW), .NUM_BANK(NB), .READ_LATENCY(L)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_a(req_a), .i_we_a(we_a), .i_addr_a(addr_a),
    .i_din_a(din_a), .i_inj_a(inj_a),
    .o_ready_a(ready_a), .o_rvalid_a(rvalid_a), .o_dout_a(dout_a),
    .o_sbe_a(sbe_a), .o_dbe_a(dbe_a),
    .i_req_b(req_b), .i_we_b(we_b), .i_addr_b(addr_b),
    .i_din_b(din_b), .i_inj_b(inj_b),
    .o_ready_b(ready_b), .o_rvalid_b(rvalid_b), .o_dout_b(dout_b),
    .o_sbe_b(sbe_b), .o_dbe_b(dbe_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [W-1:0] d;
    int         kind;
  } exp_t;

  exp_t         qa[$];
  exp_t         qb[$];
  logic [W-1:0] mem_m [DEPTH];
  int           kind_m [DEPTH];
  bit           prio_b_m;
  logic [W-1:0] last_a, last_b;
  int           edge_n;
  int           errors, checks;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit ra, input bit wa, input int aa,
                       input int da, input int ia, input bit rb,
                       input bit wb, input int ab, input int db,
                       input int ib);
    req_a = ra; we_a = wa; addr_a = AW'(aa); din_a = W'(da); inj_a = 2'(ia);
    req_b = rb; we_b = wb; addr_b = AW'(ab); din_b = W'(db); inj_b = 2'(ib);
  endtask

  task automatic apply(input int p, input bit acc, input bit we,
                       input logic [AW-1:0] a, input logic [W-1:0] d,
                       input logic [1:0] inj);
    exp_t e;
    if (!acc) return;
    if (we) begin
      mem_m[a]  = d;
      kind_m[a] = (inj == 2'b01) ? 1 : (inj == 2'b10) ? 2 : 0;
    end else begin
      e.due  = edge_n + L;
      e.d    = mem_m[a];
      e.kind = kind_m[a];
      if (p == 0) qa.push_back(e);
      else qb.push_back(e);
    end
  endtask

  task automatic check_outs();
    exp_t e;
    bit   hit;
    hit = 0;
    if (qa.size() > 0 && qa[0].due == edge_n) begin
      e = qa.pop_front(); hit = 1;
    end
    chk("rvalid_a", 64'(rvalid_a), 64'(hit));
    if (hit) last_a = e.d;
    chk("dout_a", 64'(dout_a), 64'(last_a));
    chk("sbe_a", 64'(sbe_a), 64'(hit && ECC && e.kind == 1));
    chk("dbe_a", 64'(dbe_a), 64'(hit && ECC && e.kind == 2));
    hit = 0;
    if (qb.size() > 0 && qb[0].due == edge_n) begin
      e = qb.pop_front(); hit = 1;
    end
    chk("rvalid_b", 64'(rvalid_b), 64'(hit));
    if (hit) last_b = e.d;
    chk("dout_b", 64'(dout_b), 64'(last_b));
    chk("sbe_b", 64'(sbe_b), 64'(hit && ECC && e.kind == 1));
    chk("dbe_b", 64'(dbe_b), 64'(hit && ECC && e.kind == 2));
  endtask

  task automatic cyc();
    bit conf, ea, eb;
    #1;
    conf = req_a && req_b && ((int'(addr_a) % NB) == (int'(addr_b) % NB));
    ea = !(conf && prio_b_m);
    eb = !(conf && !prio_b_m);
    chk("ready_a", 64'(ready_a), 64'(ea));
    chk("ready_b", 64'(ready_b), 64'(eb));
    @(posedge clk);
    edge_n++;
    if (conf) prio_b_m = !prio_b_m;
    apply(0, req_a && ea, we_a, addr_a, din_a, inj_a);
    apply(1, req_b && eb, we_b, addr_b, din_b, inj_b);
    #1;
    check_outs();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic reset_model();
    qa.delete();
    qb.delete();
    last_a = '0;
    last_b = '0;
    prio_b_m = 0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    edge_n = 0;
    reset_model();
    for (int i = 0; i < DEPTH; i++) kind_m[i] = 0;

    #2 rst_n = 1'b0;
    #1 check_outs();
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;

    // Fill memory: even words on A, odd on B (always different banks).
    for (int i = 0; i < DEPTH; i += 2) begin
      drive(1, 1, i, (i < 8) ? i : $urandom_range(0, 255), 0,
            1, 1, i + 1, (i + 1 < 8) ? i + 1 : $urandom_range(0, 255), 0);
      cyc();
    end

    for (int i = 0; i < 8; i++) begin
      drive(1, 0, i, 0, 0, 0, 0, 0, 0, 0);
      cyc();
    end
    idle(L + 2);

    drive(1, 1, 3, 'hA5, 0, 0, 0, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 1, 0, 3, 0, 0);
    cyc();
    idle(L + 2);

    drive(1, 0, 4, 0, 0, 1, 1, 8, 'h5A, 0);
    cyc();
    drive(1, 0, 12, 0, 0, 1, 1, 8, 'h5A, 0);
    cyc();
    drive(1, 0, 12, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 1, 0, 8, 0, 0);
    cyc();
    idle(L + 2);

    drive(1, 1, 9, 'h3C, 1, 0, 0, 0, 0, 0);
    cyc();
    drive(1, 0, 9, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    drive(1, 1, 10, 'h3C, 2, 0, 0, 0, 0, 0);
    cyc();
    drive(1, 0, 10, 0, 0, 1, 0, 9, 0, 0);
    cyc();
    idle(L + 2);

    for (int i = 0; i < 150; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, DEPTH - 1), $urandom_range(0, 255),
            $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, DEPTH - 1), $urandom_range(0, 255),
            $urandom_range(0, 3));
      cyc();
    end
    idle(L + 2);

    // Read in flight when reset hits must never come back.
    drive(1, 0, 1, 0, 0, 1, 0, 2, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    reset_model();
    #1 check_outs();
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;
    idle(L + 3);

    drive(1, 0, 5, 0, 0, 1, 0, 6, 0, 0);
    cyc();
    idle(L + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
